// File: rtl/stream_demux.sv
// stream_demux: routes packets from one valid/ready stream to one of NUM_OUTPUTS registered output slots.
module stream_demux #(
  parameter int WIDTH = 8,
  parameter int SEL_WIDTH = 3,
  parameter int NUM_OUTPUTS = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_last,
  input  logic [SEL_WIDTH-1:0]         sel,
  output logic [NUM_OUTPUTS-1:0]       out_valid,
  input  logic [NUM_OUTPUTS-1:0]       out_ready,
  output logic [NUM_OUTPUTS*WIDTH-1:0] out_data,
  output logic [NUM_OUTPUTS-1:0]       out_last,
  output logic [CNT_WIDTH-1:0]         drop_cnt,
  output logic                         busy
);
  typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;
  localparam logic [SEL_WIDTH:0] N_OUT = NUM_OUTPUTS[SEL_WIDTH:0];
  state_t state_q, state_d;
  logic [SEL_WIDTH-1:0] dest_q, dest_d, tgt;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic [NUM_OUTPUTS-1:0] valid_q, last_q;
  logic [NUM_OUTPUTS*WIDTH-1:0] data_q;
  logic sel_ok, tgt_free, accept, wr_en, drop_inc;
  always_comb begin
    sel_ok = {1'b0, sel} < N_OUT;
    tgt = state_q == ROUTE ? dest_q : sel;
    tgt_free = 1'b0;
    for (int i = 0; i < NUM_OUTPUTS; i++)
      if (tgt == SEL_WIDTH'(i)) tgt_free = !valid_q[i] || out_ready[i];
    in_ready = state_q == DROP || (state_q == IDLE && !sel_ok) || tgt_free;
    accept = in_valid && in_ready;
    wr_en = accept && (state_q == ROUTE || (state_q == IDLE && sel_ok));
    drop_inc = accept && in_last && (state_q == DROP || (state_q == IDLE && !sel_ok));
    drop_d = drop_inc && drop_q != '1 ? drop_q + CNT_WIDTH'(1) : drop_q;
    dest_d = accept && state_q == IDLE ? sel : dest_q;
    state_d = !accept ? state_q : in_last ? IDLE : state_q != IDLE ? state_q : sel_ok ? ROUTE : DROP;
  end
  // A write and a drain in the same cycle keep the slot full with the new beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dest_q <= '0;
      drop_q <= '0;
      valid_q <= '0;
      last_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      dest_q <= dest_d;
      drop_q <= drop_d;
      for (int i = 0; i < NUM_OUTPUTS; i++)
        if (wr_en && tgt == SEL_WIDTH'(i)) begin
          valid_q[i] <= 1'b1;
          last_q[i] <= in_last;
          data_q[i*WIDTH +: WIDTH] <= in_data;
        end else if (out_ready[i]) valid_q[i] <= 1'b0;
    end
  end
  assign out_valid = valid_q;
  assign out_data = data_q;
  assign out_last = last_q;
  assign drop_cnt = drop_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed stimulus with a per-output scoreboard and a reference routing model.
module tb_stream_demux;
  localparam int N = 6;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, in_last = 0, busy;
  logic [7:0] in_data = '0, drop_cnt;
  logic [2:0] sel = '0;
  logic [N-1:0] out_valid, out_ready = '0, out_last;
  logic [N*8-1:0] out_data;
  int n_cmp = 0, n_bad = 0;
  logic [8:0] q [N][$];
  int m_state = 0, m_dest = 0, m_drop = 0;
  bit mon_en = 0;
  time t0;

  stream_demux #(.WIDTH(8), .SEL_WIDTH(3), .NUM_OUTPUTS(N), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .drop_cnt(drop_cnt), .busy(busy));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: scoreboard drains and routing model, all sampled on the falling edge.
  always @(negedge clk) begin
    if (!mon_en) begin
      if (rst) mon_en = 1;
    end else begin
      check("busy", busy, m_state != 0);
      check("drop_cnt", drop_cnt, m_drop);
      for (int i = 0; i < N; i++)
        if (q[i].size() == 0) check("idle_valid", out_valid[i], 0);
        else if (out_valid[i]) begin
          check("slot", {out_last[i], out_data[i*8 +: 8]}, q[i][0]);
          if (out_ready[i]) void'(q[i].pop_front());
        end
      if (rst) begin
        for (int i = 0; i < N; i++) q[i].delete();
        m_state = 0;
        m_drop = 0;
      end else if (in_valid && in_ready) begin
        if (m_state == 0) begin
          if (sel < N) begin
            q[sel].push_back({in_last, in_data});
            m_dest = sel;
            m_state = in_last ? 0 : 1;
          end else if (in_last) m_drop = m_drop < 255 ? m_drop + 1 : 255;
          else m_state = 2;
        end else if (m_state == 1) begin
          q[m_dest].push_back({in_last, in_data});
          if (in_last) m_state = 0;
        end else if (in_last) begin
          m_state = 0;
          m_drop = m_drop < 255 ? m_drop + 1 : 255;
        end
      end
    end
  end

  task automatic beat(input logic [2:0] s, input logic [7:0] d, input logic l);
    bit ok = 0;
    in_valid = 1;
    sel = s;
    in_data = d;
    in_last = l;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
    end
    check("accept_timeout", ok, 1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    check("rst_drop", drop_cnt, 0);
    @(posedge clk);
    #1 out_ready = '1;
    beat(3, 8'hA5, 1);
    @(negedge clk);
    check("t1_valid", out_valid, 6'h08);
    check("t1_data", out_data[3*8 +: 8], 8'hA5);
    check("t1_last", out_last, 6'h08);
    check("t1_busy", busy, 0);
    @(negedge clk);
    check("t1_drained", out_valid, 0);
    @(posedge clk);
    #1 beat(5, 8'h10, 0);
    beat(2, 8'h11, 0);
    beat(2, 8'h12, 0);
    beat(2, 8'h13, 1);
    repeat (3) @(posedge clk);
    #1 out_ready = 6'b111101;
    beat(1, 8'h21, 0);
    in_valid = 1;
    in_data = 8'h22;
    in_last = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_ready", in_ready, 0);
      check("bp_hold", out_data[1*8 +: 8], 8'h21);
    end
    @(posedge clk);
    #1 out_ready = '1;
    beat(1, 8'h22, 0);
    beat(1, 8'h23, 1);
    t0 = $time;
    beat(7, 8'h40, 0);
    beat(7, 8'h41, 0);
    beat(7, 8'h42, 1);
    check("drop_rate", 32'($time - t0), 30);
    @(negedge clk);
    check("drop_one", drop_cnt, 1);
    for (int k = 0; k < 300; k++) beat(7, 8'(k), 1);
    @(negedge clk);
    check("drop_sat", drop_cnt, 255);
    @(posedge clk);
    #1 beat(0, 8'h30, 0);
    in_valid = 1;
    in_data = 8'h31;
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    in_valid = 0;
    @(negedge clk);
    check("mr_valid", out_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_drop", drop_cnt, 0);
    @(posedge clk);
    #1 beat(4, 8'h32, 0);
    beat(4, 8'h33, 1);
    t0 = $time;
    for (int k = 0; k < 6; k++) beat(2, 8'h50 + 8'(k), k % 2 == 1);
    check("b2b_rate", 32'($time - t0), 60);
    repeat (4) @(negedge clk);
    for (int i = 0; i < N; i++) check("leftover", q[i].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Packet-routing demultiplexer: one valid/ready input stream is steered to one of NUM_OUTPUTS valid/ready output streams.
- The destination is taken from sel on the first beat of each packet and locked until the beat carrying in_last.
- Each output has a one-entry registered slot, so outputs are registered and input-to-output latency is 1 cycle.
- Packets whose destination is out of range are consumed and discarded; drops are counted.

Parameters:
- WIDTH, 8: data width of every stream.
- SEL_WIDTH, 3: width of sel.
- NUM_OUTPUTS, 8: number of destinations; must satisfy 1 <= NUM_OUTPUTS <= 2**SEL_WIDTH.
- CNT_WIDTH, 8: width of the drop counter.

Ports:
- clk, input, 1: clock; all logic on the rising edge.
- rst, input, 1: synchronous active-high reset.
- in_valid, input, 1: input beat valid.
- in_ready, output, 1: input beat accepted when in_valid && in_ready.
- in_data, input, WIDTH: input payload.
- in_last, input, 1: final beat of the packet.
- sel, input, SEL_WIDTH: destination index; sampled only on the first beat of a packet.
- out_valid, output, NUM_OUTPUTS: per-output valid; bit i belongs to destination i.
- out_ready, input, NUM_OUTPUTS: per-output ready.
- out_data, output, NUM_OUTPUTS*WIDTH: slot i occupies bits [i*WIDTH +: WIDTH].
- out_last, output, NUM_OUTPUTS: per-output last flag.
- drop_cnt, output, CNT_WIDTH: saturating count of discarded packets.
- busy, output, 1: high while a packet is in progress, i.e. state != IDLE.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State returns to IDLE.
  - All out_valid = 0; out_data and out_last = 0.
  - drop_cnt = 0; busy = 0.
  - Reset mid-packet abandons the packet. The remaining beats of that packet are treated as a new packet when they arrive.
- FSM states: IDLE, ROUTE, DROP.
  - IDLE: the first accepted beat decides the path.
    - If sel < NUM_OUTPUTS: latch dest = sel and write the beat to slot dest.
    - Else: discard the beat.
    - If in_last on that beat: stay in IDLE. For a dropped single-beat packet, increment drop_cnt.
    - Otherwise: go to ROUTE (valid sel) or DROP (invalid sel).
  - ROUTE: every accepted beat goes to slot dest; sel is ignored. An accepted beat with in_last returns the FSM to IDLE.
  - DROP: in_ready = 1 and beats are discarded. An accepted beat with in_last returns the FSM to IDLE and increments drop_cnt.
    - A packet counts exactly once, on its last beat.
- in_ready is combinational from state, sel and the slots:
  - IDLE with sel in range: in_ready = !out_valid[sel] || out_ready[sel].
  - IDLE with sel out of range, and DROP: in_ready = 1.
  - ROUTE: in_ready = !out_valid[dest] || out_ready[dest].
  - in_ready never depends on in_valid.
- Slot i, per cycle:
  - On an accepted write: out_valid[i] <= 1 and out_data/out_last are loaded.
  - Else if out_valid[i] && out_ready[i]: out_valid[i] <= 0.
  - Else: hold.
  - A simultaneous drain and write of the same slot keeps out_valid = 1 with the new data, giving full throughput of 1 beat/cycle.
  - Slot contents are stable while out_valid[i] && !out_ready[i].
- Latency: a beat accepted at edge N appears on out_* after edge N; it may drain at edge N+1 at the earliest.
- Ordering: beats of a packet appear on the destination in input order, with no gaps introduced by the block.
- Slots drain independently. Other slots continue to drain while the input stalls on a full destination.
- drop_cnt saturates at 2**CNT_WIDTH-1 and does not wrap.
- sel out of range is not a simulation error: no assertion fires. Handling is functional (DROP).

Test Plan:
- Reset, then a single-beat packet with sel=3, in_data=0xA5, in_last=1, out_ready all 1 -> out_valid=8'h08 for one cycle, slot 3 = 0xA5 with last=1, busy stays 0, drop_cnt=0.
- 4-beat packet 0x10..0x13, sel=5 on beat 0 and sel=2 on beats 1-3, out_ready[5]=1 -> all four beats on output 5 on consecutive cycles, out_last only on 0x13, busy high from after beat 0 until after the last beat, output 2 never valid.
- Backpressure: out_ready[1]=0 for 3 cycles during a 3-beat packet to output 1 -> in_ready=0 while slot 1 is full, first beat held stable, then all 3 beats delivered in order with none lost or duplicated; other outputs keep draining.
- NUM_OUTPUTS=6, sel=7: a 3-beat packet is accepted at 1 beat/cycle and out_valid stays 0 -> drop_cnt goes to 1 on the last beat; 300 further single-beat invalid packets with CNT_WIDTH=8 -> drop_cnt saturates at 255.
- Assert rst during beat 2 of a 4-beat packet to output 0 -> the next cycle shows out_valid=0, busy=0, drop_cnt=0; beats 3-4 (sel=4) are routed to output 4 as a new packet.
- Back-to-back packets to the same output with out_ready held 1 -> 1 beat/cycle throughput, out_valid never drops between packets.
